// File: rtl/dii_packet_tx_if.sv
// DII ring channel: 16-bit flits with first/last framing and a valid/ready handshake.
// The master drives flits toward the router; the slave (router local input) returns ready.
interface dii_packet_tx_if;
    logic [15:0] data;
    logic        first;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, output first, output last, output valid, input ready);
    modport slave  (input data, input first, input last, input valid, output ready);
endinterface

// File: rtl/dii_packet_tx.sv
// Serializes one debug message per request into a DII packet: dest, src, type, then payload flits.
// Outputs are registered; a new request is taken in the same cycle the final flit handshakes.
module dii_packet_tx #(
    parameter int MAX_PAYLOAD = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [9:0]                         id,
    input  logic                               req_valid,
    output logic                               req_ready,
    input  logic [9:0]                         req_dest,
    input  logic [15:0]                        req_type,
    input  logic [$clog2(MAX_PAYLOAD+1)-1:0]   req_len,
    input  logic [16*MAX_PAYLOAD-1:0]          req_payload,
    output logic                               req_err,
    dii_packet_tx_if.master                    out
);
    localparam int LW = $clog2(MAX_PAYLOAD + 1);
    localparam logic [LW-1:0] MAXL = LW'(MAX_PAYLOAD);

    typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD} state_t;

    state_t                    state;
    logic [9:0]                src_r;
    logic [15:0]               type_r;
    logic [LW-1:0]             len_r;
    logic [LW-1:0]             cnt;
    logic [16*MAX_PAYLOAD-1:0] pl_r;
    logic [LW-1:0]             len_clamped;
    logic                      hs;
    logic                      done;
    logic                      accept;

    assign hs          = out.valid && out.ready;
    assign done        = hs && out.last;
    // Ready in the final-flit cycle lets the next packet follow without a bubble.
    assign req_ready   = !rst && (state == IDLE || done);
    assign accept      = req_valid && req_ready;
    assign len_clamped = (req_len > MAXL) ? MAXL : req_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            out.valid <= 1'b0;
            out.first <= 1'b0;
            out.last  <= 1'b0;
            out.data  <= '0;
            req_err   <= 1'b0;
            src_r     <= '0;
            type_r    <= '0;
            len_r     <= '0;
            cnt       <= '0;
            pl_r      <= '0;
        end else begin
            req_err <= 1'b0;
            if (accept) begin
                state     <= DEST;
                src_r     <= id;
                type_r    <= req_type;
                len_r     <= len_clamped;
                pl_r      <= req_payload;
                cnt       <= '0;
                req_err   <= (req_len > MAXL);
                out.valid <= 1'b1;
                out.first <= 1'b1;
                out.last  <= 1'b0;
                out.data  <= {6'b0, req_dest};
            end else if (done) begin
                state     <= IDLE;
                out.valid <= 1'b0;
                out.first <= 1'b0;
                out.last  <= 1'b0;
                out.data  <= '0;
            end else if (hs) begin
                case (state)
                    DEST: begin
                        state     <= SRC;
                        out.first <= 1'b0;
                        out.data  <= {6'b0, src_r};
                    end
                    SRC: begin
                        state    <= TYPE;
                        out.data <= type_r;
                        out.last <= (len_r == '0);
                    end
                    // Payload is shifted out low flit first; cnt counts flits already presented.
                    TYPE: begin
                        state    <= PAYLOAD;
                        out.data <= pl_r[15:0];
                        pl_r     <= pl_r >> 16;
                        cnt      <= LW'(1);
                        out.last <= (len_r == LW'(1));
                    end
                    PAYLOAD: begin
                        out.data <= pl_r[15:0];
                        pl_r     <= pl_r >> 16;
                        cnt      <= cnt + 1'b1;
                        out.last <= ((cnt + 1'b1) == len_r);
                    end
                    default: begin
                        state     <= IDLE;
                        out.valid <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dii_packet_tx.sv
// Scoreboard bench for dii_packet_tx: requests push expected flits, a monitor pops and compares.
module tb_dii_packet_tx;
    localparam int MAXP = 8;
    localparam int LW   = $clog2(MAXP + 1);

    typedef struct {
        logic [15:0] d;
        logic        f;
        logic        l;
        int          ec;
    } flit_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [9:0]           id = '0;
    logic                 req_valid = 1'b0;
    logic                 req_ready;
    logic [9:0]           req_dest = '0;
    logic [15:0]          req_type = '0;
    logic [LW-1:0]        req_len = '0;
    logic [16*MAXP-1:0]   req_payload = '0;
    logic                 req_err;

    dii_packet_tx_if out_if ();

    dii_packet_tx #(.MAX_PAYLOAD(MAXP)) dut (
        .clk        (clk),
        .rst        (rst),
        .id         (id),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_dest   (req_dest),
        .req_type   (req_type),
        .req_len    (req_len),
        .req_payload(req_payload),
        .req_err    (req_err),
        .out        (out_if)
    );

    always #5 clk = ~clk;

    int    cyc = 0;
    int    nchk = 0;
    int    nfail = 0;
    int    err_cyc = -10;
    int    ready_mode = 0;
    int    last_acc = 0;
    flit_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a packet is dest, own id, type, then min(len, MAXP) payload words in order.
    task automatic model_push(input logic [9:0] d, input logic [15:0] t, input logic [LW-1:0] l,
                              input logic [16*MAXP-1:0] p, input int acc, input bit hi);
        logic [15:0] fl[$];
        flit_t f;
        int ln;
        int n;
        ln = int'(l);
        n  = (ln > MAXP) ? MAXP : ln;
        fl.push_back({6'b0, d});
        fl.push_back({6'b0, id});
        fl.push_back(t);
        for (int k = 0; k < n; k++) fl.push_back(p[16*k +: 16]);
        for (int i = 0; i < fl.size(); i++) begin
            f.d  = fl[i];
            f.f  = (i == 0);
            f.l  = (i == fl.size() - 1);
            f.ec = hi ? acc + 1 + i : -1;
            sbq.push_back(f);
        end
        if (ln > MAXP) err_cyc = acc + 1;
    endtask

    // Called and returns at posedge+1; leaves fields scrambled after acceptance.
    task automatic send(input logic [9:0] d, input logic [15:0] t, input logic [LW-1:0] l,
                        input logic [16*MAXP-1:0] p);
        bit ok;
        ok          = 1'b0;
        req_valid   = 1'b1;
        req_dest    = d;
        req_type    = t;
        req_len     = l;
        req_payload = p;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1'b1;
                last_acc = cyc;
                model_push(d, t, l, p, cyc, ready_mode == 0);
            end
        end
        if (!ok) begin
            nchk++;
            nfail++;
            $display("FAIL accept_timeout: got no req_ready expected acceptance (cycle %0d)", cyc);
        end
        @(posedge clk);
        #1;
        req_valid   = 1'b0;
        req_dest    = 10'($urandom);
        req_type    = 16'($urandom);
        req_len     = LW'($urandom);
        req_payload = {$urandom, $urandom, $urandom, $urandom};
        id          = 10'($urandom);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_if.valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sbq.size() != 0 || out_if.valid) begin
            nchk++;
            nfail++;
            $display("FAIL drain_timeout: got %0d pending flits expected 0", sbq.size());
            sbq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Ready source: 0 = always high, 1 = random, 2 = repeating 1,0,0,1.
    initial begin
        int pidx;
        pidx = 0;
        out_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_if.ready = 1'b1;
                1:       out_if.ready = 1'($urandom_range(0, 1));
                default: out_if.ready = (pidx % 4 == 0) || (pidx % 4 == 3);
            endcase
            pidx++;
        end
    end

    // Monitor: compares every handshaked flit, stall stability and the req_err pulse.
    initial begin
        flit_t       e;
        bit          stall;
        logic [15:0] sd;
        logic        sf;
        logic        sl;
        stall = 1'b0;
        sd = '0;
        sf = 1'b0;
        sl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
                continue;
            end
            chk("req_err", {31'b0, req_err}, {31'b0, cyc == err_cyc});
            if (stall) begin
                chk("stall_valid", {31'b0, out_if.valid}, 32'd1);
                chk("stall_data", {16'b0, out_if.data}, {16'b0, sd});
                chk("stall_frame", {30'b0, out_if.first, out_if.last}, {30'b0, sf, sl});
            end
            if (out_if.valid && out_if.ready) begin
                if (sbq.size() == 0) begin
                    nchk++;
                    nfail++;
                    $display("FAIL extra_flit: got %04h expected no flit", out_if.data);
                end else begin
                    e = sbq.pop_front();
                    chk("flit_data", {16'b0, out_if.data}, {16'b0, e.d});
                    chk("flit_frame", {30'b0, out_if.first, out_if.last}, {30'b0, e.f, e.l});
                    if (e.ec >= 0) chk("flit_cycle", cyc, e.ec);
                    if (e.l) chk("ready_on_last", {31'b0, req_ready}, 32'd1);
                end
            end
            stall = out_if.valid && !out_if.ready;
            sd = out_if.data;
            sf = out_if.first;
            sl = out_if.last;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        nfail++;
        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_valid", {31'b0, out_if.valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {13'b0, out_if.valid, out_if.first, out_if.last, out_if.data},
            32'd0);
        chk("post_rst_req_err", {31'b0, req_err}, 32'd0);
        chk("post_rst_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Reference packet with ready held high.
        ready_mode = 0;
        id = 10'h005;
        send(10'h012, 16'h4000, LW'(2), {96'b0, 16'hBBBB, 16'hAAAA});
        drain();

        // Header-only packet.
        id = 10'h155;
        send(10'h3FF, 16'h1234, LW'(0), '0);
        drain();

        // Stalls during a packet.
        ready_mode = 2;
        id = 10'h0A5;
        send(10'h021, 16'h8001, LW'(2), {96'b0, 16'h5678, 16'h9ABC});
        drain();

        // Back-to-back packets.
        ready_mode = 0;
        send(10'h001, 16'h0101, LW'(1), {112'b0, 16'hCAFE});
        send(10'h002, 16'h0202, LW'(0), '0);
        send(10'h003, 16'h0303, LW'(3), {80'b0, 16'h3333, 16'h2222, 16'h1111});
        drain();

        // Over-long length is clamped and flagged.
        send(10'h044, 16'hEEEE, LW'(MAXP + 3), {$urandom, $urandom, $urandom, $urandom});
        drain();
        ready_mode = 1;
        send(10'h045, 16'hEEEF, LW'(MAXP), {$urandom, $urandom, $urandom, $urandom});
        drain();

        // Reset while payload flit 1 is on the bus.
        ready_mode = 0;
        send(10'h066, 16'h6666, LW'(2), {96'b0, 16'h0BB0, 16'h0AA0});
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        sbq.delete();
        @(negedge clk);
        chk("mid_rst_req_ready", {31'b0, req_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'b0, out_if.valid}, 32'd0);
        chk("abort_last", {31'b0, out_if.last}, 32'd0);
        chk("abort_req_ready", {31'b0, req_ready}, 32'd1);
        @(posedge clk);
        #1;
        send(10'h077, 16'h7777, LW'(1), {112'b0, 16'h7070});
        drain();

        // Randomized batches, mixing ready patterns, gaps and lengths.
        for (int b = 0; b < 12; b++) begin
            ready_mode = $urandom_range(0, 2);
            for (int k = 0; k < int'($urandom_range(2, 5)); k++) begin
                id = 10'($urandom);
                send(10'($urandom), 16'($urandom), LW'($urandom_range(0, MAXP + 3)),
                     {$urandom, $urandom, $urandom, $urandom});
                repeat ($urandom_range(0, 1)) begin
                    @(posedge clk);
                    #1;
                end
            end
            drain();
        end

        $display("[TB] %0d tests run, %0d failed", nchk, nfail);
        $finish;
    end
endmodule
